// File: rtl/serial_pattern_pkg.sv
// Shared definitions for the serial pattern transmitter.
//   state_t          : FSM state encoding (IDLE, SHIFT, GAP, DONE)
//   DEFAULT_IDLE_BIT : line level when nothing is being sent
//   eff_repeats()    : maps a requested repeat count to the number actually sent
package serial_pattern_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic DEFAULT_IDLE_BIT = 1'b0;

    // A request for zero repetitions still sends the pattern once.
    function automatic int unsigned eff_repeats(input int unsigned n);
        return (n == 0) ? 32'd1 : n;
    endfunction

endpackage

// File: rtl/serial_pattern_tx_piso.sv
// Parallel-in / serial-out shift register, MSB first.
//   i_clk, i_rst  : clock, synchronous active-high reset
//   i_load        : load i_data (has priority over i_shift)
//   i_shift       : shift left by one, zero fill
//   i_data        : parallel word to load
//   o_serial_next : MSB the register will hold after the coming edge
module piso_shift_reg #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic             i_shift,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_serial_next
);

    logic [WIDTH-1:0] r_sr;
    logic [WIDTH-1:0] w_sr_d;

    always_comb begin
        w_sr_d = r_sr;
        if (i_load) begin
            w_sr_d = i_data;
        end else if (i_shift) begin
            w_sr_d = {r_sr[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sr <= '0;
        end else begin
            r_sr <= w_sr_d;
        end
    end

    // The top registers its output bit, so it needs the value the MSB is about to take.
    assign o_serial_next = w_sr_d[WIDTH-1];

endmodule

// File: rtl/serial_pattern_tx.sv
// Serial bit-pattern transmitter.
// Accepts a WIDTH-bit pattern and a repeat count over valid/ready, then sends the
// pattern MSB-first one bit per clock, N times, with GAP idle cycles between
// repetitions, followed by a one-cycle done pulse.
//   i_clk, i_rst    : clock, synchronous active-high reset
//   i_start_valid   : transmit request
//   o_start_ready   : request can be accepted (combinational)
//   i_pattern       : bits to send, captured on accept
//   i_repeat_n      : number of transmissions (0 behaves as 1)
//   o_out           : serial data (registered)
//   o_out_valid     : o_out carries a pattern bit (registered)
//   o_busy          : FSM not idle
//   o_done          : one-cycle pulse after the final bit (registered)
module serial_pattern_tx
    import serial_pattern_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CNT_W    = 4,
    parameter int unsigned GAP      = 1,
    parameter logic        IDLE_BIT = DEFAULT_IDLE_BIT
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start_valid,
    output logic             o_start_ready,
    input  logic [WIDTH-1:0] i_pattern,
    input  logic [CNT_W-1:0] i_repeat_n,
    output logic             o_out,
    output logic             o_out_valid,
    output logic             o_busy,
    output logic             o_done
);

    localparam int unsigned BIT_W    = $clog2(WIDTH);
    localparam int unsigned GAP_W    = (GAP > 1) ? $clog2(GAP) : 1;
    localparam int unsigned GAP_LAST = (GAP > 0) ? GAP - 1 : 0;

    state_t             r_state;
    state_t             w_state_d;
    logic [BIT_W-1:0]   r_bit_cnt;
    logic [GAP_W-1:0]   r_gap_cnt;
    logic [CNT_W-1:0]   r_reps_left;
    logic [WIDTH-1:0]   r_pattern;
    logic               r_out;
    logic               r_out_valid;
    logic               r_done;

    logic               w_accept;
    logic               w_last_bit;
    logic               w_last_rep;
    logic               w_gap_end;
    logic               w_load;
    logic               w_shift;
    logic [WIDTH-1:0]   w_load_data;
    logic               w_serial_next;
    logic               w_out_d;
    logic               w_out_valid_d;
    logic               w_done_d;

    assign o_start_ready = (r_state == S_IDLE) && !i_rst;
    assign w_accept      = i_start_valid && o_start_ready;
    assign w_last_bit    = (r_state == S_SHIFT) && (r_bit_cnt == BIT_W'(WIDTH - 1));
    assign w_last_rep    = (r_reps_left == CNT_W'(1));
    assign w_gap_end     = (r_state == S_GAP) && (r_gap_cnt == GAP_W'(GAP_LAST));

    // Reload from the held copy for every repetition after the first.
    assign w_load      = w_accept || w_gap_end ||
                         (w_last_bit && !w_last_rep && (GAP == 0));
    assign w_shift     = (r_state == S_SHIFT) && !w_load;
    assign w_load_data = w_accept ? i_pattern : r_pattern;

    piso_shift_reg #(
        .WIDTH (WIDTH)
    ) u_piso (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_load        (w_load),
        .i_shift       (w_shift),
        .i_data        (w_load_data),
        .o_serial_next (w_serial_next)
    );

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_d = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (w_last_bit) begin
                    if (w_last_rep) begin
                        w_state_d = S_DONE;
                    end else if (GAP > 0) begin
                        w_state_d = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (w_gap_end) begin
                    w_state_d = S_SHIFT;
                end
            end
            S_DONE: begin
                w_state_d = S_IDLE;
            end
            default: begin
                w_state_d = S_IDLE;
            end
        endcase
    end

    // Output logic, evaluated on the next state so the outputs can be registered
    always_comb begin
        w_out_d       = IDLE_BIT;
        w_out_valid_d = 1'b0;
        w_done_d      = 1'b0;
        if (w_state_d == S_SHIFT) begin
            w_out_d       = w_serial_next;
            w_out_valid_d = 1'b1;
        end
        if (w_state_d == S_DONE) begin
            w_done_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_bit_cnt   <= '0;
            r_gap_cnt   <= '0;
            r_reps_left <= '0;
            r_pattern   <= '0;
            r_out       <= IDLE_BIT;
            r_out_valid <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_out       <= w_out_d;
            r_out_valid <= w_out_valid_d;
            r_done      <= w_done_d;

            if (r_state == S_SHIFT && !w_last_bit) begin
                r_bit_cnt <= r_bit_cnt + BIT_W'(1);
            end else begin
                r_bit_cnt <= '0;
            end

            if (r_state == S_GAP && !w_gap_end) begin
                r_gap_cnt <= r_gap_cnt + GAP_W'(1);
            end else begin
                r_gap_cnt <= '0;
            end

            if (w_accept) begin
                r_pattern   <= i_pattern;
                r_reps_left <= CNT_W'(eff_repeats(32'(i_repeat_n)));
            end else if (w_last_bit) begin
                r_reps_left <= r_reps_left - CNT_W'(1);
            end
        end
    end

    assign o_out       = r_out;
    assign o_out_valid = r_out_valid;
    assign o_done      = r_done;
    assign o_busy      = (r_state != S_IDLE);

endmodule
